// File: rtl/unified_mem_arbiter.sv
// Single-ported byte memory shared by instruction fetch and data load/store.
// A per-cycle arbiter grants at most one requester; data wins by default and
// fetch is forced through after STARVE_MAX consecutive losses. Every grant
// produces exactly one registered response one cycle later.
module unified_mem_arbiter #(
  parameter int DEPTH      = 256,
  parameter int DATA_BASE  = 128,
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_fault,
  // data load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_fault
);

  localparam int IW        = $clog2(DEPTH);
  localparam int SW        = $clog2(STARVE_MAX + 1);
  localparam int DATA_SPAN = DEPTH - DATA_BASE;

  logic [7:0]    mem [DEPTH];

  logic [SW-1:0] starve_q, starve_d;
  logic          if_gnt_d, d_gnt_d;

  logic [IW-1:0] f_idx, d_idx, a_idx, a_idx1, a_idx2, a_idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rd_word;

  logic          d_mis, d_ill, d_fault_d, if_fault_d;
  logic [31:0]   ld_data, d_rdata_d, if_rdata_d;

  logic          if_rvalid_q, if_fault_q, d_rvalid_q, d_fault_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  // Arbitration: data by default, fetch when alone or when starved; no grants in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    if_gnt_d = 1'b0;
    d_gnt_d  = 1'b0;
    if (!rst) begin
      if (if_req && (starve_q == SW'(STARVE_MAX) || !d_req)) begin
        if_gnt_d = 1'b1;
      end else if (d_req) begin
        d_gnt_d = 1'b1;
      end
    end
  end

  // Starvation counter: counts consecutive fetch losses, saturating at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt_d) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Region mapping: fetch sees the low region, data is offset into the high region.
  assign f_idx = IW'(if_addr % ADDR_W'(DATA_BASE));
  assign d_idx = IW'(DATA_BASE) + IW'(d_addr % ADDR_W'(DATA_SPAN));

  // The single array port follows whichever requester holds the grant.
  assign a_idx  = if_gnt_d ? f_idx : d_idx;
  assign a_idx1 = a_idx + IW'(1);
  assign a_idx2 = a_idx + IW'(2);
  assign a_idx3 = a_idx + IW'(3);

  assign b0      = mem[a_idx];
  assign b1      = mem[a_idx1];
  assign b2      = mem[a_idx2];
  assign b3      = mem[a_idx3];
  assign rd_word = {b3, b2, b1, b0};

  // Data access legality: alignment by size, and funct3 codes that are not valid for the access.
  always_comb begin
    d_mis = 1'b0;
    case (d_funct3[1:0])
      2'b01:   d_mis = d_addr[0];
      2'b10:   d_mis = |d_addr[1:0];
      default: d_mis = 1'b0;
    endcase
    d_ill     = (d_funct3 == 3'b011) || (d_funct3[2:1] == 2'b11) || (d_we && d_funct3[2]);
    d_fault_d = d_mis || d_ill;
  end

  // Load extension by funct3; stores and faults return zero.
  always_comb begin
    ld_data = '0;
    case (d_funct3)
      3'b000:  ld_data = {{24{b0[7]}}, b0};
      3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, b0};
      3'b101:  ld_data = {16'h0, b1, b0};
      default: ld_data = '0;
    endcase
    d_rdata_d = (d_we || d_fault_d) ? 32'h0 : ld_data;
  end

  // Fetch response: whole words only, zero data when misaligned.
  assign if_fault_d = |if_addr[1:0];
  assign if_rdata_d = if_fault_d ? 32'h0 : rd_word;

  // Store write port: legal granted stores write 1, 2 or 4 bytes at the edge ending the grant cycle.
  // NOTE: the storage array has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (d_gnt_d && d_we && !d_fault_d) begin
      mem[a_idx] <= d_wdata[7:0];
      if (d_funct3[1:0] != 2'b00) begin
        mem[a_idx1] <= d_wdata[15:8];
      end
      if (d_funct3[1]) begin
        mem[a_idx2] <= d_wdata[23:16];
        mem[a_idx3] <= d_wdata[31:24];
      end
    end
  end

  // Registered state: starvation counter and one-cycle responses; reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_fault_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_fault_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_gnt_d;
      if_rdata_q  <= if_gnt_d ? if_rdata_d : 32'h0;
      if_fault_q  <= if_gnt_d && if_fault_d;
      d_rvalid_q  <= d_gnt_d;
      d_rdata_q   <= d_gnt_d ? d_rdata_d : 32'h0;
      d_fault_q   <= d_gnt_d && d_fault_d;
    end
  end

  assign if_gnt    = if_gnt_d;
  assign d_gnt     = d_gnt_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_fault  = if_fault_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_fault   = d_fault_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with default parameters.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt, if_rvalid, if_fault;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [13:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_fault;
  logic [31:0] d_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  unified_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_fault  (if_fault),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_fault   (d_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One data access with no competing fetch: grant same cycle, response next cycle only.
  task automatic do_data(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                         input string tag);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
    #1 check({tag, ".gnt"}, 32'(d_gnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    check({tag, ".rvalid"}, 32'(d_rvalid), 32'd1);
    check({tag, ".rdata"},  d_rdata, exp_rd);
    check({tag, ".fault"},  32'(d_fault), 32'(exp_f));
    @(posedge clk); #1;
    check({tag, ".rvalid_drop"}, 32'(d_rvalid), 32'd0);
  endtask

  // One fetch with no competing data request.
  task automatic do_fetch(input logic [13:0] addr, input logic [31:0] exp_rd, input logic exp_f,
                          input string tag);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    #1 check({tag, ".gnt"}, 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    check({tag, ".rvalid"}, 32'(if_rvalid), 32'd1);
    check({tag, ".rdata"},  if_rdata, exp_rd);
    check({tag, ".fault"},  32'(if_fault), 32'(exp_f));
    @(posedge clk); #1;
    check({tag, ".rvalid_drop"}, 32'(if_rvalid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;

    // Fetch region image (only reachable through the fetch port).
    dut.mem[0]  = 8'h13; dut.mem[1]  = 8'h00; dut.mem[2]  = 8'h00; dut.mem[3]  = 8'h00;
    dut.mem[4]  = 8'h01; dut.mem[5]  = 8'h02; dut.mem[6]  = 8'h03; dut.mem[7]  = 8'h04;
    dut.mem[72] = 8'hEF; dut.mem[73] = 8'hBE; dut.mem[74] = 8'hAD; dut.mem[75] = 8'h0B;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.if_gnt",    32'(if_gnt),    32'd0);
    check("rst.d_gnt",     32'(d_gnt),     32'd0);
    check("rst.if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst.d_rvalid",  32'(d_rvalid),  32'd0);
    check("rst.d_rdata",   d_rdata,        32'h0);
    check("rst.if_rdata",  if_rdata,       32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: preload byte 128..131 and read the word back.
    do_data(1'b1, 3'b010, 14'd0, 32'h00000011, 32'h0, 1'b0, "t1.sw0");
    do_data(1'b0, 3'b010, 14'd0, 32'h0, 32'h00000011, 1'b0, "t1.lw0");

    // 2: byte/half stores and sign/zero extension.
    do_data(1'b1, 3'b010, 14'd32, 32'h00000000, 32'h0, 1'b0, "t2.sw32");
    do_data(1'b1, 3'b000, 14'd32, 32'hABCD1280, 32'h0, 1'b0, "t2.sb32");
    do_data(1'b0, 3'b000, 14'd32, 32'h0, 32'hFFFFFF80, 1'b0, "t2.lb32");
    do_data(1'b0, 3'b100, 14'd32, 32'h0, 32'h00000080, 1'b0, "t2.lbu32");
    do_data(1'b0, 3'b101, 14'd32, 32'h0, 32'h00000080, 1'b0, "t2.lhu32");
    do_data(1'b0, 3'b001, 14'd32, 32'h0, 32'h00000080, 1'b0, "t2.lh32");
    do_data(1'b1, 3'b001, 14'd34, 32'h12348001, 32'h0, 1'b0, "t2.sh34");
    do_data(1'b0, 3'b001, 14'd34, 32'h0, 32'hFFFF8001, 1'b0, "t2.lh34");
    do_data(1'b0, 3'b101, 14'd34, 32'h0, 32'h00008001, 1'b0, "t2.lhu34");
    do_data(1'b0, 3'b010, 14'd32, 32'h0, 32'h80010080, 1'b0, "t2.lw32");

    // 3: both requesters held for 8 cycles -> D D D I D D D I (bit set = fetch wins).
    pat = 8'b1000_1000;
    @(negedge clk);
    if_req = 1'b1; if_addr = 14'd0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 14'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("t3.if_gnt[%0d]", i), 32'(if_gnt), 32'(pat[i]));
      check($sformatf("t3.d_gnt[%0d]", i),  32'(d_gnt),  32'(!pat[i]));
      @(posedge clk); #1;
      if (i == 7) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      check($sformatf("t3.if_rvalid[%0d]", i), 32'(if_rvalid), 32'(pat[i]));
      check($sformatf("t3.d_rvalid[%0d]", i),  32'(d_rvalid),  32'(!pat[i]));
      if (pat[i]) check($sformatf("t3.if_rdata[%0d]", i), if_rdata, 32'h00000013);
      else        check($sformatf("t3.d_rdata[%0d]", i),  d_rdata,  32'h00000011);
      @(negedge clk);
    end
    @(posedge clk); #1;
    check("t3.if_rvalid_end", 32'(if_rvalid), 32'd0);
    check("t3.d_rvalid_end",  32'(d_rvalid),  32'd0);

    // 4: misaligned and illegal accesses fault, return zero, and leave the array alone.
    do_data(1'b0, 3'b010, 14'd2,  32'h0, 32'h0, 1'b1, "t4.lw2");
    do_data(1'b0, 3'b001, 14'd5,  32'h0, 32'h0, 1'b1, "t4.lh5");
    do_data(1'b1, 3'b100, 14'd0,  32'hFFFFFFFF, 32'h0, 1'b1, "t4.st100");
    do_data(1'b0, 3'b010, 14'd0,  32'h0, 32'h00000011, 1'b0, "t4.lw0_unchanged");
    do_data(1'b1, 3'b001, 14'd33, 32'hFFFFFFFF, 32'h0, 1'b1, "t4.sh33");
    do_data(1'b1, 3'b010, 14'd34, 32'hFFFFFFFF, 32'h0, 1'b1, "t4.sw34");
    do_data(1'b0, 3'b010, 14'd32, 32'h0, 32'h80010080, 1'b0, "t4.lw32_unchanged");
    do_data(1'b0, 3'b011, 14'd0,  32'h0, 32'h0, 1'b1, "t4.ld011");
    do_data(1'b0, 3'b110, 14'd0,  32'h0, 32'h0, 1'b1, "t4.ld110");
    do_fetch(14'd6, 32'h0, 1'b1, "t4.fetch6");

    // 5: store/load round trip, region wrap and fetch mapping.
    do_data(1'b1, 3'b010, 14'd8,   32'hDEADBEEF, 32'h0, 1'b0, "t5.sw8");
    do_data(1'b0, 3'b010, 14'd8,   32'h0, 32'hDEADBEEF, 1'b0, "t5.lw8");
    do_data(1'b0, 3'b000, 14'd9,   32'h0, 32'hFFFFFFBE, 1'b0, "t5.lb9");
    do_data(1'b1, 3'b010, 14'd124, 32'hCAFEF00D, 32'h0, 1'b0, "t5.sw124");
    do_data(1'b0, 3'b010, 14'd124, 32'h0, 32'hCAFEF00D, 1'b0, "t5.lw124");
    do_data(1'b0, 3'b010, 14'd128, 32'h0, 32'h00000011, 1'b0, "t5.lw128_wrap");
    do_fetch(14'd200, 32'h0BADBEEF, 1'b0, "t5.fetch200");
    do_fetch(14'd4,   32'h04030201, 1'b0, "t5.fetch4");
    do_fetch(14'd132, 32'h04030201, 1'b0, "t5.fetch132");

    // 6: reset during a granted load drops the response; a reissued load works.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 14'd8;
    #1 check("t6.gnt", 32'(d_gnt), 32'd1);
    rst = 1'b1;
    #1 check("t6.gnt_in_rst", 32'(d_gnt), 32'd0);
    @(posedge clk); #1;
    check("t6.d_rvalid",  32'(d_rvalid),  32'd0);
    check("t6.if_rvalid", 32'(if_rvalid), 32'd0);
    check("t6.d_rdata",   d_rdata,        32'h0);
    check("t6.d_fault",   32'(d_fault),   32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_data(1'b0, 3'b010, 14'd8, 32'h0, 32'hDEADBEEF, 1'b0, "t6.lw8_reissue");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
